// File: rtl/cnt_event_gen_if.sv
// Event-conditioner bus: raw event/clear requests in, counter controls out.
interface cnt_event_gen_if;
  logic       EVT_A;
  logic       EVT_B;
  logic       CLR_REQ;
  logic       UP_ENABLE;
  logic       UP_ENABLE2;
  logic       CLEAR;
  logic       BUSY;
  logic [7:0] DROP_CNT;

  // Event source / counter side
  modport master (
    output EVT_A, EVT_B, CLR_REQ,
    input  UP_ENABLE, UP_ENABLE2, CLEAR, BUSY, DROP_CNT
  );

  // Conditioner side
  modport slave (
    input  EVT_A, EVT_B, CLR_REQ,
    output UP_ENABLE, UP_ENABLE2, CLEAR, BUSY, DROP_CNT
  );
endinterface

// File: rtl/cnt_event_gen.sv
// Conditions two async event lines and a clear request into up-counter
// enable/clear pulses: sync, debounce, rising-edge detect, serialise
// coincident enables, generate a fixed CLEAR pulse and count dropped enables.
module cnt_event_gen #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYC     = 4,
  parameter int unsigned CLR_LEN     = 2
) (
  input logic            CLK,
  input logic            RSTN,
  cnt_event_gen_if.slave bus
);

  localparam int unsigned DEB_W = $clog2(DEB_CYC + 1);
  localparam int unsigned CLR_W = (CLR_LEN > 1) ? $clog2(CLR_LEN) : 1;
  localparam int unsigned DRP_W = 8;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_LEN - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR      = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic [SYNC_STAGES-1:0] sync_c;
  logic [1:0]             syn;
  logic                   clr_syn;

  logic [1:0]             filt;
  logic [1:0]             filt_q;
  logic [DEB_W-1:0]       deb_cnt [2];
  logic [1:0]             evt;

  state_t                 state;
  state_t                 state_nxt;
  logic [CLR_W-1:0]       clr_cnt;
  logic [CLR_W-1:0]       clr_cnt_nxt;

  logic                   pend_b;
  logic                   pend_b_nxt;
  logic                   ue_q;
  logic                   ue_nxt;
  logic                   ue2_q;
  logic                   ue2_nxt;
  logic                   clear_q;
  logic                   clear_nxt;
  logic                   busy_q;
  logic                   busy_nxt;
  logic [1:0]             drop_inc;
  logic [DRP_W:0]         drop_sum;
  logic [DRP_W-1:0]       drop_cnt;
  logic [DRP_W-1:0]       drop_cnt_nxt;

  // Metastability chains for the three raw async inputs
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync_a <= '0;
      sync_b <= '0;
      sync_c <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], bus.EVT_A};
      sync_b <= {sync_b[SYNC_STAGES-2:0], bus.EVT_B};
      sync_c <= {sync_c[SYNC_STAGES-2:0], bus.CLR_REQ};
    end
  end

  assign syn     = {sync_b[SYNC_STAGES-1], sync_a[SYNC_STAGES-1]};
  assign clr_syn = sync_c[SYNC_STAGES-1];

  // Debounce: accept a new level after DEB_CYC consecutive differing cycles
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      filt   <= '0;
      filt_q <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (syn[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          filt[i]    <= syn[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Qualified rising edges of the filtered levels; bit 0 = A, bit 1 = B
  assign evt = filt & ~filt_q;

  // State and output registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      pend_b   <= 1'b0;
      ue_q     <= 1'b0;
      ue2_q    <= 1'b0;
      clear_q  <= 1'b0;
      busy_q   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      clr_cnt  <= clr_cnt_nxt;
      pend_b   <= pend_b_nxt;
      ue_q     <= ue_nxt;
      ue2_q    <= ue2_nxt;
      clear_q  <= clear_nxt;
      busy_q   <= busy_nxt;
      drop_cnt <= drop_cnt_nxt;
    end
  end

  // Clear FSM next state, enable arbitration and drop accounting
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    pend_b_nxt  = pend_b;
    ue_nxt      = 1'b0;
    ue2_nxt     = 1'b0;
    drop_inc    = 2'd0;

    case (state)
      IDLE: begin
        if (clr_syn) begin
          state_nxt   = CLR;
          clr_cnt_nxt = '0;
        end
      end
      CLR: begin
        if (clr_cnt == CLR_LAST) begin
          state_nxt = WAIT_REL;
        end else begin
          clr_cnt_nxt = clr_cnt + CLR_W'(1);
        end
      end
      WAIT_REL: begin
        if (!clr_syn) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    clear_nxt = (state_nxt == CLR);
    busy_nxt  = (state_nxt != IDLE);

    // Anything that would issue alongside CLEAR is discarded and counted
    if (clear_nxt) begin
      drop_inc   = 2'(evt[0]) + 2'(evt[1]) + 2'(pend_b);
      pend_b_nxt = 1'b0;
    end else begin
      if (pend_b) begin
        ue2_nxt    = 1'b1;
        pend_b_nxt = 1'b0;
      end
      if (evt[0]) begin
        ue_nxt = 1'b1;
        if (evt[1]) pend_b_nxt = 1'b1;
      end else if (evt[1]) begin
        ue2_nxt = 1'b1;
      end
    end

    drop_sum     = {1'b0, drop_cnt} + (DRP_W + 1)'(drop_inc);
    drop_cnt_nxt = drop_sum[DRP_W] ? {DRP_W{1'b1}} : drop_sum[DRP_W-1:0];
  end

  assign bus.UP_ENABLE  = ue_q;
  assign bus.UP_ENABLE2 = ue2_q;
  assign bus.CLEAR      = clear_q;
  assign bus.BUSY       = busy_q;
  assign bus.DROP_CNT   = drop_cnt;

endmodule

// File: tb/tb_cnt_event_gen.sv
// Directed bench for cnt_event_gen with default parameters (2/4/2).
module tb_cnt_event_gen;

  logic CLK;
  logic RSTN;

  cnt_event_gen_if bus ();

  cnt_event_gen #(
    .SYNC_STAGES(2),
    .DEB_CYC    (4),
    .CLR_LEN    (2)
  ) u_dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  // Window stimulus: EVT_A high for edges [0,a_hi), EVT_B for [b_dly,b_dly+b_hi),
  // CLR_REQ for [c_dly,c_dly+c_hi). *_at = first window cycle (after edge n)
  // the output is high, -1 if never.
  typedef struct {
    int a_hi;
    int b_hi;
    int b_dly;
    int c_hi;
    int c_dly;
    int ue_n;
    int ue2_n;
    int clr_n;
    int busy_n;
    int ue_at;
    int ue2_at;
    int clr_at;
    int drop;
  } vec_t;

  localparam int NVEC = 13;
  localparam int WIN  = 40;

  vec_t vecs [NVEC];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_window(input int a_hi, input int b_hi, input int b_dly,
                            input int c_hi, input int c_dly, input int len,
                            output int ue_n, output int ue2_n, output int clr_n,
                            output int busy_n, output int ue_at, output int ue2_at,
                            output int clr_at, output int ovl);
    ue_n = 0; ue2_n = 0; clr_n = 0; busy_n = 0;
    ue_at = -1; ue2_at = -1; clr_at = -1; ovl = 0;
    for (int i = 0; i < len; i++) begin
      bus.EVT_A   = (i < a_hi);
      bus.EVT_B   = (i >= b_dly) && (i < b_dly + b_hi);
      bus.CLR_REQ = (i >= c_dly) && (i < c_dly + c_hi);
      @(posedge CLK);
      #1;
      if (bus.UP_ENABLE)  begin ue_n++;  if (ue_at  < 0) ue_at  = i; end
      if (bus.UP_ENABLE2) begin ue2_n++; if (ue2_at < 0) ue2_at = i; end
      if (bus.CLEAR)      begin clr_n++; if (clr_at < 0) clr_at = i; end
      if (bus.BUSY) busy_n++;
      if ((bus.UP_ENABLE && bus.UP_ENABLE2) ||
          (bus.CLEAR && (bus.UP_ENABLE || bus.UP_ENABLE2))) ovl++;
    end
    bus.EVT_A   = 1'b0;
    bus.EVT_B   = 1'b0;
    bus.CLR_REQ = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    int ue_n, ue2_n, clr_n, busy_n, ue_at, ue2_at, clr_at, ovl;
    int d0;
    int waited;
    string tag;

    //           a   b  bd  c  cd  ue ue2 clr busy uat u2at cat drop
    vecs[0]  = '{ 0,  0,  0,  0, 0,  0, 0,  0,  0, -1, -1, -1, 0}; // quiet
    vecs[1]  = '{10,  0,  0,  0, 0,  1, 0,  0,  0,  6, -1, -1, 0}; // single A
    vecs[2]  = '{ 3,  0,  0,  0, 0,  0, 0,  0,  0, -1, -1, -1, 0}; // glitch
    vecs[3]  = '{ 4,  0,  0,  0, 0,  1, 0,  0,  0,  6, -1, -1, 0}; // min accepted
    vecs[4]  = '{ 0, 10,  0,  0, 0,  0, 1,  0,  0, -1,  6, -1, 0}; // single B
    vecs[5]  = '{10, 10,  0,  0, 0,  1, 1,  0,  0,  6,  7, -1, 0}; // coincident
    vecs[6]  = '{10, 10,  1,  0, 0,  1, 1,  0,  0,  6,  7, -1, 0}; // B one later
    vecs[7]  = '{ 0,  0,  0, 10, 0,  0, 0,  2, 10, -1, -1,  2, 0}; // clear held
    vecs[8]  = '{ 0,  0,  0,  1, 0,  0, 0,  2,  3, -1, -1,  2, 0}; // clear pulse
    vecs[9]  = '{10,  0,  0, 10, 4,  0, 0,  2, 10, -1, -1,  6, 1}; // A dropped
    vecs[10] = '{10, 10,  0, 10, 4,  0, 0,  2, 10, -1, -1,  6, 2}; // A+B dropped
    vecs[11] = '{10, 10,  0, 10, 5,  1, 0,  2, 10,  6, -1,  7, 1}; // pending B dropped
    vecs[12] = '{ 0, 10, 10, 20, 4,  0, 1,  2, 20, -1, 16,  6, 0}; // B in WAIT_REL

    // Reset state
    RSTN = 1'b0;
    bus.EVT_A = 1'b0; bus.EVT_B = 1'b0; bus.CLR_REQ = 1'b0;
    ticks(4);
    chk("reset_outputs",
        int'({bus.UP_ENABLE, bus.UP_ENABLE2, bus.CLEAR, bus.BUSY, bus.DROP_CNT}), 0);
    RSTN = 1'b1;

    // Table of windowed scenarios
    for (int v = 0; v < NVEC; v++) begin
      d0 = int'(bus.DROP_CNT);
      run_window(vecs[v].a_hi, vecs[v].b_hi, vecs[v].b_dly, vecs[v].c_hi,
                 vecs[v].c_dly, WIN, ue_n, ue2_n, clr_n, busy_n,
                 ue_at, ue2_at, clr_at, ovl);
      tag = $sformatf("v%0d", v);
      chk({tag, "_ue_n"},   ue_n,   vecs[v].ue_n);
      chk({tag, "_ue2_n"},  ue2_n,  vecs[v].ue2_n);
      chk({tag, "_clr_n"},  clr_n,  vecs[v].clr_n);
      chk({tag, "_busy_n"}, busy_n, vecs[v].busy_n);
      chk({tag, "_ue_at"},  ue_at,  vecs[v].ue_at);
      chk({tag, "_ue2_at"}, ue2_at, vecs[v].ue2_at);
      chk({tag, "_clr_at"}, clr_at, vecs[v].clr_at);
      chk({tag, "_drop"},   int'(bus.DROP_CNT) - d0, vecs[v].drop);
      chk({tag, "_overlap"}, ovl, 0);
    end

    // DROP_CNT saturation: 150 windows of two drops each from a fresh reset
    RSTN = 1'b0;
    ticks(2);
    RSTN = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      run_window(8, 8, 0, 3, 4, 24, ue_n, ue2_n, clr_n, busy_n,
                 ue_at, ue2_at, clr_at, ovl);
      if (k == 1)   chk("sat_first", int'(bus.DROP_CNT), 2);
      if (k == 127) chk("sat_254",   int'(bus.DROP_CNT), 254);
    end
    chk("sat_255", int'(bus.DROP_CNT), 255);

    // Reset during CLEAR pulse
    bus.CLR_REQ = 1'b1;
    waited = 0;
    while (!bus.CLEAR && waited < 10) begin
      ticks(1);
      waited++;
    end
    chk("rst_clr_seen", int'(bus.CLEAR), 1);
    RSTN = 1'b0;
    bus.CLR_REQ = 1'b0;
    #1;
    chk("rst_clr_abort", int'({bus.CLEAR, bus.BUSY}), 0);
    chk("rst_clr_drop0", int'(bus.DROP_CNT), 0);
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    run_window(0, 0, 0, 0, 0, 20, ue_n, ue2_n, clr_n, busy_n,
               ue_at, ue2_at, clr_at, ovl);
    chk("rst_clr_idle", clr_n + busy_n, 0);

    // Reset while B is pending behind A
    bus.EVT_A = 1'b1;
    bus.EVT_B = 1'b1;
    waited = 0;
    while (!bus.UP_ENABLE && waited < 15) begin
      ticks(1);
      waited++;
    end
    chk("rst_pend_ue_seen", int'(bus.UP_ENABLE), 1);
    RSTN = 1'b0;
    bus.EVT_A = 1'b0;
    bus.EVT_B = 1'b0;
    #1;
    chk("rst_pend_abort", int'({bus.UP_ENABLE, bus.UP_ENABLE2}), 0);
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    run_window(0, 0, 0, 0, 0, 20, ue_n, ue2_n, clr_n, busy_n,
               ue_at, ue2_at, clr_at, ovl);
    chk("rst_pend_no_ue2", ue2_n + ue_n, 0);

    // Input held high through reset release yields exactly one event
    RSTN = 1'b0;
    bus.EVT_A = 1'b1;
    ticks(2);
    RSTN = 1'b1;
    run_window(30, 0, 0, 0, 0, 30, ue_n, ue2_n, clr_n, busy_n,
               ue_at, ue2_at, clr_at, ovl);
    chk("held_thru_reset", ue_n, 1);
    chk("held_thru_reset_at", ue_at, 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
